// File: rtl/calc_pkg.sv
// Shared definitions for the calculator trig/reciprocal path.
//   SCALE    : fixed-point scale factor (values are x * SCALE)
//   OP_*     : operation encodings carried on the 2-bit op bus
//   state_t  : sequencer state encoding
package calc_pkg;

  localparam int SCALE = 10000;

  localparam logic [1:0] OP_TAN   = 2'b00;
  localparam logic [1:0] OP_COT   = 2'b01;
  localparam logic [1:0] OP_SEC   = 2'b10;
  localparam logic [1:0] OP_COSEC = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIG  = 2'd1,
    SETUP = 2'd2,
    DIV   = 2'd3
  } state_t;

endpackage

// File: rtl/seq_div32.sv
// Restoring divider, one quotient bit per enabled cycle.
//   clk      : clock, rising edge
//   load     : capture dividend into the shift register, clear remainder
//   en       : perform one restoring step this cycle
//   dividend : 32-bit unsigned dividend (sampled on load)
//   divisor  : 16-bit unsigned divisor (must stay stable while stepping)
//   quotient : quotient bits so far; while en is high this already
//              includes the bit being produced on the coming edge, so the
//              caller can take the final value on the 32nd step edge
module seq_div32 (
  input  logic        clk,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic [31:0] quotient
);

  // Dividend bits shift out of the top while quotient bits shift in at
  // the bottom; after 32 steps the register holds the full quotient.
  logic [31:0] q_q;
  logic [15:0] rem_q;

  logic [16:0] rem_sh;
  logic [16:0] rem_n;
  logic [31:0] q_n;
  logic        ge;

  always_comb begin
    rem_sh = {rem_q, q_q[31]};
    ge     = (rem_sh >= {1'b0, divisor});
    rem_n  = ge ? (rem_sh - {1'b0, divisor}) : rem_sh;
    q_n    = {q_q[30:0], ge};
  end

  assign quotient = en ? q_n : q_q;

  always_ff @(posedge clk) begin
    if (load) begin
      q_q   <= dividend;
      rem_q <= '0;
    end else if (en) begin
      q_q   <= q_n;
      // Remainder is always below the divisor, so 16 bits suffice.
      rem_q <= rem_n[15:0];
    end
  end

endmodule

// File: rtl/trig_recip_seq.sv
// Multi-cycle tan/cot/sec/cosec controller.
// Drives a shared combinational Sin/Cos evaluator, then divides with a
// 1-bit-per-cycle restoring divider. Values are unsigned, scaled by SCALE.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, op, inp1 : request, operation (00 tan 01 cot 10 sec 11 cosec), angle
//   trig_angle      : angle presented to the Sin/Cos evaluator
//   sin_val/cos_val : evaluator return, valid one cycle after trig_angle
//   busy, done      : in-flight flag and one-cycle completion pulse
//   result          : truncated quotient, saturated to 16'hFFFF
//   div_zero, ovf   : divisor was zero / quotient exceeded 16 bits
module trig_recip_seq #(
  parameter int DW    = 16,
  parameter int SCALE = 10000,
  parameter int QW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] inp1,
  output logic [DW-1:0] trig_angle,
  input  logic [DW-1:0] sin_val,
  input  logic [DW-1:0] cos_val,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          div_zero,
  output logic          ovf
);

  import calc_pkg::*;

  localparam logic [QW-1:0] SCALE_Q  = QW'(SCALE);
  localparam logic [QW-1:0] SCALE_SQ = SCALE_Q * SCALE_Q;

  state_t        state_q, state_d;
  logic [1:0]    op_q;
  logic [4:0]    cnt_q;
  logic [DW-1:0] sin_q, cos_q;

  logic          accept, div_load, div_en, fin_zero, fin_div;
  logic [QW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic [QW-1:0] quotient;
  logic          q_hi_nz;

  // Next-state and per-cycle control strobes
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    div_load = 1'b0;
    div_en   = 1'b0;
    fin_zero = 1'b0;
    fin_div  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = TRIG;
        end
      end
      TRIG:  state_d = SETUP;
      SETUP: begin
        if (divisor == '0) begin
          fin_zero = 1'b1;
          state_d  = IDLE;
        end else begin
          div_load = 1'b1;
          state_d  = DIV;
        end
      end
      DIV: begin
        div_en = 1'b1;
        if (cnt_q == 5'd31) begin
          fin_div = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand selection from the captured sin/cos pair
  always_comb begin
    dividend = SCALE_SQ;
    divisor  = cos_q;
    case (op_q)
      OP_TAN:   begin dividend = QW'(sin_q) * SCALE_Q; divisor = cos_q; end
      OP_COT:   begin dividend = QW'(cos_q) * SCALE_Q; divisor = sin_q; end
      OP_SEC:   begin dividend = SCALE_SQ;             divisor = cos_q; end
      default:  begin dividend = SCALE_SQ;             divisor = sin_q; end
    endcase
  end

  seq_div32 u_div (
    .clk      (clk),
    .load     (div_load),
    .en       (div_en),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient)
  );

  assign q_hi_nz = |quotient[QW-1:DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      cnt_q      <= '0;
      trig_angle <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      div_zero   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q       <= op;
        trig_angle <= inp1;
        busy       <= 1'b1;
        div_zero   <= 1'b0;
        ovf        <= 1'b0;
      end
      if (div_load) cnt_q <= '0;
      else if (div_en) cnt_q <= cnt_q + 5'd1;
      if (fin_zero) begin
        result   <= '1;
        div_zero <= 1'b1;
        done     <= 1'b1;
        busy     <= 1'b0;
      end
      if (fin_div) begin
        result <= q_hi_nz ? '1 : quotient[DW-1:0];
        ovf    <= q_hi_nz;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

  // Evaluator return is registered one cycle after trig_angle settles
  always_ff @(posedge clk) begin
    if (state_q == TRIG) begin
      sin_q <= sin_val;
      cos_q <= cos_val;
    end
  end

endmodule

// File: tb/tb_trig_recip_seq.sv
module tb_trig_recip_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] inp1;
  logic [15:0] trig_angle;
  logic [15:0] sin_val, cos_val;
  logic        busy, done, div_zero, ovf;
  logic [15:0] result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trig_recip_seq #(.DW(16), .SCALE(10000), .QW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .inp1       (inp1),
    .trig_angle (trig_angle),
    .sin_val    (sin_val),
    .cos_val    (cos_val),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .div_zero   (div_zero),
    .ovf        (ovf)
  );

  // Sin/Cos evaluator model: small table of the angles used below
  always_comb begin
    sin_val = 16'd0;
    cos_val = 16'd10000;
    case (trig_angle)
      16'd0:  begin sin_val = 16'd0;    cos_val = 16'd10000; end
      16'd30: begin sin_val = 16'd5000; cos_val = 16'd8660;  end
      16'd45: begin sin_val = 16'd7071; cos_val = 16'd7071;  end
      16'd60: begin sin_val = 16'd8660; cos_val = 16'd5000;  end
      16'd89: begin sin_val = 16'd9998; cos_val = 16'd175;   end
      default: begin sin_val = 16'd1234; cos_val = 16'd4321; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Step edges after the accept until done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input int exp_lat, input logic [15:0] exp_res,
                        input logic exp_dz, input logic exp_ovf);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; inp1 = a;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; inp1 = 16'd77;
    chk({tag, "_busy_acc"}, busy, 1'b1);
    chk({tag, "_dz_clr"}, div_zero, 1'b0);
    chk({tag, "_ovf_clr"}, ovf, 1'b0);
    chk({tag, "_angle"}, trig_angle, a);
    wait_done(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_dz"}, div_zero, exp_dz);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_res_hold"}, result, exp_res);
    chk({tag, "_dz_hold"}, div_zero, exp_dz);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; inp1 = 16'd0;
    #23;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 16'd0);
    chk("rst_dz", div_zero, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_angle", trig_angle, 16'd0);
    @(negedge clk); rst_n = 1'b1;

    // 70710000/7071, 86600000/5000, 1e8/5000
    run_op("tan45",  2'b00, 16'd45, 34, 16'd10000, 1'b0, 1'b0);
    run_op("cot30",  2'b01, 16'd30, 34, 16'd17320, 1'b0, 1'b0);
    run_op("sec60",  2'b10, 16'd60, 34, 16'd20000, 1'b0, 1'b0);
    run_op("cosec0", 2'b11, 16'd0,   2, 16'hFFFF,  1'b1, 1'b0);
    // 99980000/175 = 571314 -> saturates
    run_op("tan89",  2'b00, 16'd89, 34, 16'hFFFF,  1'b0, 1'b1);
    // 1e8/8660 = 11547
    run_op("cosec60", 2'b11, 16'd60, 34, 16'd11547, 1'b0, 1'b0);

    // start while busy is ignored; start in the done cycle is accepted
    @(negedge clk); start = 1'b1; op = 2'b00; inp1 = 16'd45;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
    start = 1'b1; op = 2'b01; inp1 = 16'd30;
    @(posedge clk); #1; start = 1'b0;
    chk("busy_ign_angle", trig_angle, 16'd45);
    wait_done(lat);
    chk("busy_ign_lat", lat + 10, 34);
    chk("busy_ign_res", result, 16'd10000);
    start = 1'b1; op = 2'b10; inp1 = 16'd60;
    @(posedge clk); #1; start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_done", done, 1'b0);
    wait_done(lat);
    chk("b2b_lat", lat, 34);
    chk("b2b_res", result, 16'd20000);

    // asynchronous reset in the middle of an operation
    @(negedge clk); start = 1'b1; op = 2'b00; inp1 = 16'd89;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 1; i < 15; i++) begin @(posedge clk); #1; end
    chk("mid_busy_pre", busy, 1'b1);
    #2; rst_n = 1'b0; #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_result", result, 16'd0);
    chk("mid_rst_angle", trig_angle, 16'd0);
    lat = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) lat++; end
    chk("mid_rst_nodone", lat, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst_cot30", 2'b01, 16'd30, 34, 16'd17320, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // done and busy must never overlap
  always @(negedge clk) begin
    if (rst_n && done && busy) begin
      failures++;
      $display("FAIL done_busy_overlap: done=%0d busy=%0d required not both", done, busy);
    end
  end

endmodule
